// File: rtl/run_scan_pkg.sv
// Shared definitions for the run-scan controller slice.
// Holds the FSM state encoding, parameter defaults and a width helper
// used to size the count/index result ports.
package run_scan_pkg;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_RUN_LEN = 3;

  // Scan FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Bits needed to hold any value in 0..width
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/run_detector_core.sv
// Serial run detector.
// Tracks the tail run of equal bits (either polarity) in the incoming
// serial stream; y goes high when that run is at least RUN_LEN long.
// Ports:
//   clk      - clock, rising edge
//   reset_n  - asynchronous active-low reset
//   clr      - synchronous clear to the "no run" state
//   x        - serial input bit, consumed every edge
//   y        - registered run-hit flag for the bits consumed so far
module run_detector_core
  import run_scan_pkg::*;
#(
  parameter int unsigned RUN_LEN = DEF_RUN_LEN
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic x,
  output logic y
);

  localparam int unsigned RW = $clog2(RUN_LEN + 1);

  logic [RW-1:0] run_cnt;
  logic [RW-1:0] run_cnt_nxt;
  logic          last_bit;

  // Next run length: restart on empty history or polarity change, saturate at RUN_LEN
  always_comb begin
    run_cnt_nxt = run_cnt;
    if ((run_cnt == '0) || (x != last_bit)) begin
      run_cnt_nxt = RW'(1);
    end else if (run_cnt != RW'(RUN_LEN)) begin
      run_cnt_nxt = run_cnt + RW'(1);
    end
  end

  // Run state and registered hit flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt  <= '0;
      last_bit <= 1'b0;
      y        <= 1'b0;
    end else if (clr) begin
      run_cnt  <= '0;
      last_bit <= 1'b0;
      y        <= 1'b0;
    end else begin
      run_cnt  <= run_cnt_nxt;
      last_bit <= x;
      y        <= (run_cnt_nxt >= RW'(RUN_LEN));
    end
  end

endmodule

// File: rtl/run_scan_ctrl.sv
// Word-level scan controller for the serial run detector.
// Captures a word on start, shifts it MSB-first through the detector one
// bit per clock, samples the detector result for every bit position and
// reports the hit count and first hit index, then pulses done.
// Ports:
//   clk           - clock, rising edge
//   reset_n       - asynchronous active-low reset
//   start         - scan request, accepted only when idle
//   data_in       - word to scan, captured on the accepting edge
//   busy          - high while shifting/draining
//   done          - one-cycle pulse, results valid
//   hit_count     - number of bit positions ending a run >= RUN_LEN
//   any_hit       - hit_count != 0
//   first_hit_idx - smallest hit index (0 = MSB), 0 when no hit
//   ser_bit       - bit currently presented to the detector
module run_scan_ctrl
  import run_scan_pkg::*;
#(
  parameter  int unsigned WIDTH   = DEF_WIDTH,
  parameter  int unsigned RUN_LEN = DEF_RUN_LEN,
  localparam int unsigned CNT_W   = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_count,
  output logic             any_hit,
  output logic [CNT_W-1:0] first_hit_idx,
  output logic             ser_bit
);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic             accept_c;
  logic             sample_c;
  logic [CNT_W-1:0] sample_idx_c;
  logic             det_y;

  // Detector sees the shift register MSB; it is cleared on the accepting edge
  run_detector_core #(
    .RUN_LEN (RUN_LEN)
  ) u_det (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (accept_c),
    .x       (shreg[WIDTH-1]),
    .y       (det_y)
  );

  assign ser_bit = shreg[WIDTH-1];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle strobes.
  // det_y lags the consumed bit by one edge, so the result for bit i is
  // sampled while bit_cnt == i+1; the last bit is picked up in DRAIN.
  always_comb begin
    state_nxt    = state;
    accept_c     = 1'b0;
    sample_c     = 1'b0;
    sample_idx_c = bit_cnt - CNT_W'(1);
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept_c  = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sample_c = (bit_cnt != '0);
        if (bit_cnt == CNT_W'(WIDTH - 1)) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        sample_c  = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Shift register, bit counter, results and registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg         <= '0;
      bit_cnt       <= '0;
      hit_count     <= '0;
      any_hit       <= 1'b0;
      first_hit_idx <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      busy <= (state_nxt == ST_SHIFT) || (state_nxt == ST_DRAIN);
      done <= (state_nxt == ST_DONE);

      if (accept_c) begin
        shreg         <= data_in;
        bit_cnt       <= '0;
        hit_count     <= '0;
        any_hit       <= 1'b0;
        first_hit_idx <= '0;
      end else if (state == ST_SHIFT) begin
        shreg   <= {shreg[WIDTH-2:0], 1'b0};
        bit_cnt <= bit_cnt + CNT_W'(1);
      end

      // Results hold outside scans; only acceptance clears them
      if (sample_c && det_y) begin
        hit_count <= hit_count + CNT_W'(1);
        if (!any_hit) begin
          any_hit       <= 1'b1;
          first_hit_idx <= sample_idx_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_run_scan_ctrl.sv
// Directed self-checking bench for run_scan_ctrl (WIDTH=8, RUN_LEN=3).
module tb_run_scan_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             reset_n;
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] hit_count;
  logic             any_hit;
  logic [CNT_W-1:0] first_hit_idx;
  logic             ser_bit;

  int n_cmp = 0;
  int n_err = 0;

  run_scan_ctrl #(
    .WIDTH   (WIDTH),
    .RUN_LEN (3)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .data_in       (data_in),
    .busy          (busy),
    .done          (done),
    .hit_count     (hit_count),
    .any_hit       (any_hit),
    .first_hit_idx (first_hit_idx),
    .ser_bit       (ser_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle at a time (sampling on negedge) until done, bounded.
  task automatic wait_done(input int k0, output int k, output int nb);
    bit found;
    found = 1'b0;
    nb    = 0;
    k     = k0;
    while (!found && (k < k0 + 40)) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (done) found = 1'b1;
      else if (busy) nb++;
    end
  endtask

  task automatic check_results(input string tag, input int hits, input int first, input int anyh);
    check({tag, "_hits"},  32'(hit_count),     32'(hits));
    check({tag, "_first"}, 32'(first_hit_idx), 32'(first));
    check({tag, "_any"},   32'(any_hit),       32'(anyh));
  endtask

  // Full scan: accept at E0, expect done at E9 and busy for 9 sampled cycles
  task automatic scan(input string tag, input logic [WIDTH-1:0] d,
                      input int hits, input int first, input int anyh);
    int k;
    int nb;
    @(negedge clk);
    data_in = d;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check({tag, "_busy_e0"}, 32'(busy), 32'd1);
    check({tag, "_ser_e0"},  32'(ser_bit), 32'(d[WIDTH-1]));
    wait_done(0, k, nb);
    check({tag, "_done_edge"}, 32'(k), 32'd9);
    check({tag, "_busy_len"},  32'(nb + 1), 32'd9);
    check_results(tag, hits, first, anyh);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check_results({tag, "_hold"}, hits, first, anyh);
  endtask

  initial begin
    int k;
    int nb;
    int ndone;
    reset_n = 1'b0;
    start   = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ser",  32'(ser_bit), 32'd0);
    check_results("rst", 0, 0, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic words
    scan("ff", 8'hFF, 6, 2, 1);
    scan("aa", 8'hAA, 0, 0, 0);
    scan("0f", 8'h0F, 4, 2, 1);
    scan("00", 8'h00, 6, 2, 1);

    // Back-to-back with start held high: second accept 11 cycles after the first
    @(negedge clk);
    data_in = 8'hE3;
    start   = 1'b1;
    @(posedge clk);
    #1 data_in = 8'h71;
    wait_done(0, k, nb);
    check("b2b1_done_edge", 32'(k), 32'd9);
    check_results("b2b1", 2, 2, 1);
    @(posedge clk);
    @(negedge clk);
    check("b2b_idle_e10", 32'(busy), 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("b2b_accept_e11", 32'(busy), 32'd1);
    check_results("b2b_clear", 0, 0, 0);
    wait_done(0, k, nb);
    check("b2b2_done_edge", 32'(k), 32'd9);
    check_results("b2b2", 2, 3, 1);

    // Start re-pulsed mid-scan with new data is ignored
    @(negedge clk);
    data_in = 8'hFF;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    data_in = 8'h00;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(4, k, nb);
    check("ign_done_edge", 32'(k), 32'd9);
    check_results("ign", 6, 2, 1);

    // Reset mid-scan at E5
    @(negedge clk);
    data_in = 8'hFF;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_ser",  32'(ser_bit), 32'd0);
    check_results("mrst", 0, 0, 0);
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) ndone++;
    end
    reset_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("mrst_no_done", 32'(ndone), 32'd0);
    scan("post_rst_aa", 8'hAA, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/run_scan_ctrl.md
Name: run_scan_ctrl

Overview:
- Word-level controller for a serial run detector.
- Accepts a parallel word on a start handshake, clears the detector and shifts the word through it MSB-first, one bit per clock.
- Samples the detector output for every bit position and reports the number of hit positions and the index of the first hit, then pulses done.
- Sits between a register/switch front-end and the serial run-detection datapath.

Parameters:
- WIDTH, 8, bits per scanned word (2..32).
- RUN_LEN, 3, minimum length of a run of identical bits that counts as a hit (2..WIDTH).
- CNT_W, $clog2(WIDTH+1), width of hit_count and first_hit_idx (derived, not overridden).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request to scan data_in; accepted only in IDLE.
- data_in  in  WIDTH  word to scan; captured on the accepting edge.
- busy  out  1  high while scanning (SHIFT and DRAIN states).
- done  out  1  one-cycle pulse: results valid.
- hit_count  out  CNT_W  number of bit positions i whose run ending at i has length >= RUN_LEN.
- any_hit  out  1  hit_count != 0.
- first_hit_idx  out  CNT_W  smallest hit index, where index 0 is the MSB. 0 when any_hit=0.
- ser_bit  out  1  bit currently presented to the detector (debug).

Behaviour:
- Reset (asynchronous):
  - state=IDLE.
  - busy=0, done=0, hit_count=0, any_hit=0, first_hit_idx=0, ser_bit=0.
  - Detector state cleared.
- Reset mid-scan aborts immediately; no done is produced.
- States: IDLE, SHIFT, DRAIN, DONE (encoding in the package).
- IDLE:
  - On an edge E0 with start=1: latch data_in into the shift register, bit_cnt=0, clear hit_count/any_hit/first_hit_idx, go to SHIFT.
  - The detector is cleared synchronously at E0, so its state after E0 is "no run".
- SHIFT:
  - ser_bit = shreg[WIDTH-1]. The shift register shifts left each edge.
  - The detector consumes bit i at edge E(i+1).
  - At each edge E(k), k=2..WIDTH, det_y is sampled as the result for bit k-2.
  - At E(WIDTH), go to DRAIN.
- DRAIN:
  - Single cycle; samples the result for bit WIDTH-1 at E(WIDTH+1), then goes to DONE.
- DONE:
  - done=1 for exactly this cycle; returns to IDLE at the next edge.
- Timing totals:
  - busy is high for WIDTH+1 cycles (E0..E(WIDTH+1)).
  - done is visible in the cycle after E(WIDTH+1).
  - Minimum start-to-start period is WIDTH+3 cycles.
- Sample rule: when det_y=1 for bit i:
  - hit_count += 1;
  - if any_hit was 0, set first_hit_idx=i and any_hit=1.
  - hit_count never exceeds WIDTH-RUN_LEN+1, so it cannot overflow.
- Result hold: results hold stable from DONE until the next accepted start; only acceptance clears them.
- start handling:
  - start in SHIFT/DRAIN/DONE is ignored and not queued.
  - data_in changes after acceptance have no effect.
- Detector semantics:
  - Moore output; y=1 when the current tail run of equal bits (either polarity) has length >= RUN_LEN.
  - A polarity change restarts the run at length 1.
  - The run counter saturates at RUN_LEN.

Decomposition:
- Package run_scan_pkg: state enum (IDLE=0, SHIFT=1, DRAIN=2, DONE=3), RUN_LEN default, CNT_W helper function.
- Sub-module run_detector_core, instantiated once:
  - Ports: clk, reset_n, clr (synchronous), x, y.
  - Holds last bit and a saturating run counter sized $clog2(RUN_LEN+1).
- run_scan_ctrl holds the FSM, shift register, bit counter and result registers.

Test Plan (WIDTH=8, RUN_LEN=3):
- data_in=8'hFF, start pulse at E0 -> busy high 9 cycles; done after E9; hit_count=6, first_hit_idx=2, any_hit=1.
- data_in=8'hAA -> hit_count=0, any_hit=0, first_hit_idx=0; done after E9.
- data_in=8'hE3, then 8'h71 back-to-back with start held high -> first result hit_count=2, first_hit_idx=2; second accepted 11 cycles after the first, result hit_count=2, first_hit_idx=3.
- data_in=8'h0F -> hit_count=4, first_hit_idx=2. Then data_in=8'h00 -> hit_count=6, first_hit_idx=2 (proves detector clear between words).
- start re-pulsed at E4 during a scan of 8'hFF, with data_in changed to 8'h00 -> ignored; results still hit_count=6, first_hit_idx=2.
- reset_n low at E5 mid-scan -> all outputs 0 asynchronously, no done. After release, a scan of 8'hAA returns hit_count=0.
